v_lane_sched: RTL and testbench

V_LANE_SCHED -- requirements
Module: v_lane_sched

---
 rtl/v_lane_sched.sv | 190 +++++++++++++++++++
 tb/tb_v_lane_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/v_lane_sched.sv
// Vector lane scheduler: runs an accepted vector op over the lane banks, one
// pass per group of banks, and strobes the result groups as each pass lands.
module v_lane_sched #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic       req_is_mul,
    input  logic [1:0] req_lmul,
    input  logic [1:0] req_lanes,
    output logic [3:0] op_instr_alu,
    output logic       is_mul,
    output logic [1:0] step,
    output logic [3:0] bank_en,
    output logic [3:0] grp_wr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [2:0] WAIT_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    // Sizes are kept as log2 values; the reserved code 11 decodes like 00.
    function automatic logic [1:0] size_log(input logic [1:0] code);
        case (code)
            2'b01:   size_log = 2'd1;
            2'b10:   size_log = 2'd2;
            default: size_log = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] low_mask(input logic [1:0] n_log);
        case (n_log)
            2'd0:    low_mask = 4'b0001;
            2'd1:    low_mask = 4'b0011;
            default: low_mask = 4'b1111;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [1:0] pass_q, pass_d;
    logic [1:0] last_q, last_d;
    logic [1:0] blog_q, blog_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [3:0] op_q, op_d;
    logic       mul_q, mul_d;
    logic [3:0] mask_q, mask_d;

    logic [3:0] op_instr_alu_q, op_instr_alu_d;
    logic       is_mul_q, is_mul_d;
    logic [1:0] step_q, step_d;
    logic [3:0] bank_en_q, bank_en_d;
    logic [3:0] grp_wr_q, grp_wr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0] glog_in, blog_in, nlog_in;
    logic [2:0] shamt;
    logic       active;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        last_d  = last_q;
        blog_d  = blog_q;
        wcnt_d  = wcnt_q;
        op_d    = op_q;
        mul_d   = mul_q;
        mask_d  = mask_q;

        glog_in = size_log(req_lmul);
        blog_in = size_log(req_lanes);
        nlog_in = (glog_in < blog_in) ? glog_in : blog_in;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    mul_d  = req_is_mul;
                    blog_d = blog_in;
                    mask_d = low_mask(nlog_in);
                    // Last pass index is G/B-1 when groups outnumber banks.
                    if (glog_in > blog_in)
                        last_d = ((glog_in - blog_in) == 2'd2) ? 2'd3 : 2'd1;
                    else
                        last_d = 2'd0;
                    pass_d  = 2'd0;
                    wcnt_d  = 3'd0;
                    state_d = (req_op == 4'd0 && !req_is_mul) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (LAT == 0) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = WAIT_INIT;
                end
            end
            WAIT: begin
                if (wcnt_q == 3'd0)
                    state_d = CAPTURE;
                else
                    wcnt_d = wcnt_q - 3'd1;
            end
            CAPTURE: begin
                if (pass_q == last_q) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    pass_d  = pass_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the next state so they register in step with it.
        active         = (state_d == ISSUE) || (state_d == WAIT) || (state_d == CAPTURE);
        shamt          = {1'b0, pass_d} << blog_d;
        op_instr_alu_d = active ? op_d : 4'd0;
        is_mul_d       = active ? mul_d : 1'b0;
        step_d         = active ? pass_d : 2'd0;
        bank_en_d      = active ? mask_d : 4'd0;
        grp_wr_d       = (state_d == CAPTURE) ? (mask_d << shamt) : 4'd0;
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pass_q         <= 2'd0;
            last_q         <= 2'd0;
            blog_q         <= 2'd0;
            wcnt_q         <= 3'd0;
            op_q           <= 4'd0;
            mul_q          <= 1'b0;
            mask_q         <= 4'd0;
            op_instr_alu_q <= 4'd0;
            is_mul_q       <= 1'b0;
            step_q         <= 2'd0;
            bank_en_q      <= 4'd0;
            grp_wr_q       <= 4'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pass_q         <= pass_d;
            last_q         <= last_d;
            blog_q         <= blog_d;
            wcnt_q         <= wcnt_d;
            op_q           <= op_d;
            mul_q          <= mul_d;
            mask_q         <= mask_d;
            op_instr_alu_q <= op_instr_alu_d;
            is_mul_q       <= is_mul_d;
            step_q         <= step_d;
            bank_en_q      <= bank_en_d;
            grp_wr_q       <= grp_wr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Ready must drop the instant reset rises, so it is not registered.
    assign req_ready    = (state_q == IDLE) && !rst;
    assign op_instr_alu = op_instr_alu_q;
    assign is_mul       = is_mul_q;
    assign step         = step_q;
    assign bank_en      = bank_en_q;
    assign grp_wr       = grp_wr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_v_lane_sched.sv
// Self-checking bench for v_lane_sched: directed scenarios plus random ops,
// each checked cycle by cycle against a pass/phase reference model.
module tb_v_lane_sched;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic       req_is_mul;
    logic [1:0] req_lmul;
    logic [1:0] req_lanes;
    logic [3:0] op_instr_alu;
    logic       is_mul;
    logic [1:0] step;
    logic [3:0] bank_en;
    logic [3:0] grp_wr;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [3:0] nx_op;
    logic       nx_mul;
    logic [1:0] nx_lmul;
    logic [1:0] nx_lanes;

    v_lane_sched #(.LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_is_mul   (req_is_mul),
        .req_lmul     (req_lmul),
        .req_lanes    (req_lanes),
        .op_instr_alu (op_instr_alu),
        .is_mul       (is_mul),
        .step         (step),
        .bank_en      (bank_en),
        .grp_wr       (grp_wr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag, input logic exp_ready);
        checkOutput({tag, "_ready"}, {3'b0, req_ready}, {3'b0, exp_ready});
        checkOutput({tag, "_op"},    op_instr_alu, 4'd0);
        checkOutput({tag, "_mul"},   {3'b0, is_mul}, 4'd0);
        checkOutput({tag, "_step"},  {2'b0, step}, 4'd0);
        checkOutput({tag, "_bank"},  bank_en, 4'd0);
        checkOutput({tag, "_grp"},   grp_wr, 4'd0);
        checkOutput({tag, "_busy"},  {3'b0, busy}, 4'd0);
        checkOutput({tag, "_done"},  {3'b0, done}, 4'd0);
    endtask

    // Presents a request while the DUT idles and returns just after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic mul,
                                 input logic [1:0] lmul, input logic [1:0] lanes);
        req_valid  = 1'b1;
        req_op     = op;
        req_is_mul = mul;
        req_lmul   = lmul;
        req_lanes  = lanes;
        #1;
        checkOutput("ready_before_accept", {3'b0, req_ready}, 4'd1);
        @(posedge clk);
        #1;
    endtask

    // Walks the whole operation plus the following idle cycle against the model.
    task automatic checkOp(input logic [3:0] op, input logic mul,
                           input logic [1:0] lmul, input logic [1:0] lanes, input bit noisy);
        int g, b, p, nb, per, n, pass, ph;
        bit nop;
        logic [3:0] e_op, e_bank, e_grp, e_full;
        logic e_mul, e_busy, e_done, e_ready;
        logic [1:0] e_step;
        g   = (lmul == 2'b01) ? 2 : (lmul == 2'b10) ? 4 : 1;
        b   = (lanes == 2'b01) ? 2 : (lanes == 2'b10) ? 4 : 1;
        p   = (g > b) ? g / b : 1;
        nb  = (g < b) ? g : b;
        per = LAT + 2;
        nop = (op == 4'd0) && !mul;
        n   = nop ? 1 : p * per + 1;
        e_full = 4'((1 << nb) - 1);
        if (!noisy) req_valid = 1'b0;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            e_op = 4'd0; e_mul = 1'b0; e_step = 2'd0; e_bank = 4'd0; e_grp = 4'd0;
            e_busy = 1'b1; e_done = 1'b0; e_ready = 1'b0;
            if (k == n + 1) begin
                e_busy  = 1'b0;
                e_ready = 1'b1;
            end else if (k == n) begin
                e_done = 1'b1;
            end else begin
                pass   = (k - 1) / per;
                ph     = (k - 1) % per;
                e_op   = op;
                e_mul  = mul;
                e_step = 2'(pass);
                e_bank = e_full;
                e_grp  = (ph == LAT + 1) ? 4'(e_full << (pass * b)) : 4'd0;
            end
            checkOutput("op",    op_instr_alu, e_op);
            checkOutput("mul",   {3'b0, is_mul}, {3'b0, e_mul});
            checkOutput("step",  {2'b0, step}, {2'b0, e_step});
            checkOutput("bank",  bank_en, e_bank);
            checkOutput("grp",   grp_wr, e_grp);
            checkOutput("busy",  {3'b0, busy}, {3'b0, e_busy});
            checkOutput("done",  {3'b0, done}, {3'b0, e_done});
            checkOutput("ready", {3'b0, req_ready}, {3'b0, e_ready});
            if (noisy && k < n) begin
                req_op     = 4'($urandom);
                req_is_mul = 1'($urandom);
                req_lmul   = 2'($urandom);
                req_lanes  = 2'($urandom);
            end else if (noisy && k == n) begin
                req_op     = nx_op;
                req_is_mul = nx_mul;
                req_lmul   = nx_lmul;
                req_lanes  = nx_lanes;
            end
        end
    endtask

    initial begin
        logic [3:0] c_op;
        logic       c_mul;
        logic [1:0] c_lmul, c_lanes;
        bit         noisy;

        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_is_mul = 1'b0;
        req_lmul = 2'd0; req_lanes = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset", 1'b0);
        rst = 1'b0;

        $display("[TB] directed: single group, one bank");
        applyStimulus(4'd3, 1'b0, 2'b00, 2'b00);
        checkOp(4'd3, 1'b0, 2'b00, 2'b00, 1'b0);

        $display("[TB] directed: four groups, one bank, multiply");
        applyStimulus(4'd0, 1'b1, 2'b10, 2'b00);
        checkOp(4'd0, 1'b1, 2'b10, 2'b00, 1'b0);

        $display("[TB] directed: four groups, two banks; one group, four banks");
        applyStimulus(4'd7, 1'b0, 2'b10, 2'b01);
        checkOp(4'd7, 1'b0, 2'b10, 2'b01, 1'b0);
        applyStimulus(4'd9, 1'b0, 2'b00, 2'b10);
        checkOp(4'd9, 1'b0, 2'b00, 2'b10, 1'b0);

        $display("[TB] directed: no-op request and reserved encodings");
        applyStimulus(4'd0, 1'b0, 2'b10, 2'b01);
        checkOp(4'd0, 1'b0, 2'b10, 2'b01, 1'b0);
        applyStimulus(4'd5, 1'b0, 2'b11, 2'b11);
        checkOp(4'd5, 1'b0, 2'b11, 2'b11, 1'b0);

        $display("[TB] directed: reset mid-operation");
        applyStimulus(4'd2, 1'b1, 2'b10, 2'b00);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy_before_abort", {3'b0, busy}, 4'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("abort_async", 1'b0);
        @(negedge clk);
        checkAllZero("abort_held", 1'b0);
        rst = 1'b0;
        applyStimulus(4'd4, 1'b0, 2'b01, 2'b00);
        checkOp(4'd4, 1'b0, 2'b01, 2'b00, 1'b0);

        $display("[TB] directed: held request with changing fields while busy");
        nx_op = 4'd6; nx_mul = 1'b1; nx_lmul = 2'b01; nx_lanes = 2'b01;
        applyStimulus(4'd8, 1'b0, 2'b10, 2'b00);
        checkOp(4'd8, 1'b0, 2'b10, 2'b00, 1'b1);
        applyStimulus(nx_op, nx_mul, nx_lmul, nx_lanes);
        checkOp(nx_op, nx_mul, nx_lmul, nx_lanes, 1'b0);

        $display("[TB] random operations");
        c_op = 4'd1; c_mul = 1'b0; c_lmul = 2'b01; c_lanes = 2'b00;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(c_op, c_mul, c_lmul, c_lanes);
            nx_op    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            nx_mul   = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            nx_lmul  = 2'($urandom_range(0, 3));
            nx_lanes = 2'($urandom_range(0, 3));
            noisy    = 1'($urandom);
            checkOp(c_op, c_mul, c_lmul, c_lanes, noisy);
            c_op = nx_op; c_mul = nx_mul; c_lmul = nx_lmul; c_lanes = nx_lanes;
        end
        req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
